// File: rtl/round_scorer_if.sv
// Bundle between the game state machine / collision logic and the round scorer.
// The master drives game state and crash flags. The slave returns round control and the scores.
interface round_scorer_if #(
  parameter int unsigned SCORE_W = 3
);
  logic [2:0]         Game_State;
  logic               Blue_Crash;
  logic               Red_Crash;
  logic               Reset_Round;
  logic               Blue_W;
  logic               Red_W;
  logic               Round_Over;
  logic               Draw;
  logic [SCORE_W-1:0] Blue_Score;
  logic [SCORE_W-1:0] Red_Score;

  modport master (
    output Game_State, Blue_Crash, Red_Crash,
    input  Reset_Round, Blue_W, Red_W, Round_Over, Draw, Blue_Score, Red_Score
  );

  modport slave (
    input  Game_State, Blue_Crash, Red_Crash,
    output Reset_Round, Blue_W, Red_W, Round_Over, Draw, Blue_Score, Red_Score
  );
endinterface

// File: rtl/round_scorer.sv
// Best-of-N match scorer: turns crash flags into round scores, a post-crash freeze,
// per-round restart pulses and match-win levels for the game state machine.
module round_scorer #(
  parameter int unsigned WINS_TO_MATCH = 3,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned SCORE_W       = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Reset_Game,
  round_scorer_if.slave      bus
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WINS_TO_MATCH);
  localparam logic [2:0]         GS_MENU    = 3'd0;
  localparam logic [2:0]         GS_STARTED = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_HOLD,
    S_ARM,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         prev_state_q, prev_state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] blue_score_q, blue_score_d;
  logic [SCORE_W-1:0] red_score_q, red_score_d;
  logic               reset_round_q, reset_round_d;
  logic               blue_w_q, blue_w_d;
  logic               red_w_q, red_w_d;
  logic               round_over_q, round_over_d;
  logic               draw_q, draw_d;

  // State and every output are registered together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_IDLE;
      prev_state_q  <= GS_MENU;
      cnt_q         <= '0;
      blue_score_q  <= '0;
      red_score_q   <= '0;
      reset_round_q <= 1'b0;
      blue_w_q      <= 1'b0;
      red_w_q       <= 1'b0;
      round_over_q  <= 1'b0;
      draw_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_state_q  <= prev_state_d;
      cnt_q         <= cnt_d;
      blue_score_q  <= blue_score_d;
      red_score_q   <= red_score_d;
      reset_round_q <= reset_round_d;
      blue_w_q      <= blue_w_d;
      red_w_q       <= red_w_d;
      round_over_q  <= round_over_d;
      draw_q        <= draw_d;
    end
  end

  // Next state and next registered outputs; Reset_Game, then Menu, take priority.
  always_comb begin
    state_d       = state_q;
    prev_state_d  = bus.Game_State;
    cnt_d         = cnt_q;
    blue_score_d  = blue_score_q;
    red_score_d   = red_score_q;
    reset_round_d = 1'b0;
    blue_w_d      = blue_w_q;
    red_w_d       = red_w_q;
    round_over_d  = round_over_q;
    draw_d        = draw_q;

    if (Reset_Game) begin
      state_d      = S_IDLE;
      prev_state_d = GS_MENU;
      cnt_d        = '0;
      blue_score_d = '0;
      red_score_d  = '0;
      blue_w_d     = 1'b0;
      red_w_d      = 1'b0;
      round_over_d = 1'b0;
      draw_d       = 1'b0;
    end else if (bus.Game_State == GS_MENU) begin
      state_d      = S_IDLE;
      blue_score_d = '0;
      red_score_d  = '0;
      blue_w_d     = 1'b0;
      red_w_d      = 1'b0;
      round_over_d = 1'b0;
      draw_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.Game_State == GS_STARTED && prev_state_q != GS_STARTED) begin
            state_d = S_PLAY;
            draw_d  = 1'b0;
          end
        end

        S_PLAY: begin
          if (bus.Blue_Crash || bus.Red_Crash) begin
            state_d      = S_HOLD;
            round_over_d = 1'b1;
            cnt_d        = HOLD_LOAD;
            if (bus.Blue_Crash && bus.Red_Crash) begin
              draw_d = 1'b1;
            end else if (bus.Blue_Crash) begin
              if (red_score_q < WIN) red_score_d = red_score_q + SCORE_W'(1);
            end else begin
              if (blue_score_q < WIN) blue_score_d = blue_score_q + SCORE_W'(1);
            end
          end else if (bus.Game_State != GS_STARTED) begin
            state_d = S_IDLE;
          end
        end

        S_HOLD: begin
          if (cnt_q == '0) begin
            round_over_d = 1'b0;
            if (blue_score_q == WIN || red_score_q == WIN) begin
              state_d = S_DONE;
              if (blue_score_q == WIN) blue_w_d = 1'b1;
              else                     red_w_d  = 1'b1;
            end else begin
              state_d       = S_ARM;
              reset_round_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_ARM: state_d = S_IDLE;

        // The win level is held until the game returns to Menu.
        S_DONE: state_d = S_DONE;

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.Reset_Round = reset_round_q;
  assign bus.Blue_W      = blue_w_q;
  assign bus.Red_W       = red_w_q;
  assign bus.Round_Over  = round_over_q;
  assign bus.Draw        = draw_q;
  assign bus.Blue_Score  = blue_score_q;
  assign bus.Red_Score   = red_score_q;

endmodule

// File: doc/round_scorer.md
# round_scorer

Match-scoring stage sitting directly upstream of the game state machine. It watches per-player crash flags from the collision logic while a round is running, keeps the best-of-N round score, and produces the three control inputs the game state machine consumes: the per-round restart pulse (`Reset_Round`) and the match-win levels (`Blue_W`, `Red_W`). It also exports live scores for the score overlay.

## Interface
- `WINS_TO_MATCH`, default 3: rounds needed to win the match; range 1 to 2^`SCORE_W`-1.
- `HOLD_CYCLES`, default 50_000_000: post-crash freeze length in clocks (≥1), so the crash stays visible.
- `SCORE_W`, default 3: score counter width.

Ports:
- `Clk`, in, 1: system clock.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `Reset_Game`, in, 1: synchronous clear, active high; same effect as reset.
- `Game_State`, in, 3: game state encoding; 0 Menu, 1 Round_Paused, 2 Round_Started, 3 Blue_Wins, 4 Red_Wins.
- `Blue_Crash`, in, 1: blue cycle collided; level, sampled only in PLAY.
- `Red_Crash`, in, 1: red cycle collided; level, sampled only in PLAY.
- `Reset_Round`, out, 1: one-cycle pulse that requests a new round.
- `Blue_W`, out, 1: blue won the match; level.
- `Red_W`, out, 1: red won the match; level.
- `Round_Over`, out, 1: high during the post-crash freeze; the movement logic stops stepping while it is high.
- `Draw`, out, 1: the last round ended with both players crashing in the same cycle; held until the next PLAY entry.
- `Blue_Score`, out, `SCORE_W`: rounds won by blue.
- `Red_Score`, out, `SCORE_W`: rounds won by red.

## Operation
- All outputs are registered Moore outputs. Reset value of every output is 0. Reset value of state is IDLE, and of `prev_state` is 0 (Menu).
- `prev_state` is a register holding `Game_State` from the previous cycle.
- **IDLE**
  - Moves to PLAY when `Game_State`==2 and `prev_state`!=2, i.e. on the rising edge into Round_Started.
  - Clears `Draw` on that transition.
- **PLAY**
  - Blue crash only: `Red_Score`+1, go to HOLD.
  - Red crash only: `Blue_Score`+1, go to HOLD.
  - Both crash in the same cycle: no score change, `Draw`=1, go to HOLD.
  - `Game_State` leaves 2 with no crash: go to IDLE, no score change.
- **HOLD**
  - `Round_Over`=1. A down-counter is loaded with `HOLD_CYCLES`-1 on entry.
  - When the counter reaches 0:
    - If either score equals `WINS_TO_MATCH`, go to DONE.
    - Otherwise go to ARM.
  - Crash inputs are ignored.
- **ARM**
  - `Reset_Round`=1 for exactly this one cycle, then go to IDLE.
- **DONE**
  - `Blue_W`=1 if `Blue_Score`==`WINS_TO_MATCH`, otherwise `Red_W`=1. Exactly one is set.
  - The level is held until `Game_State`==0.
- **Menu in any state** (`Game_State`==0): clear both scores, `Draw`, `Blue_W`, `Red_W` and `Round_Over`, then go to IDLE. This takes priority over every other transition except reset and `Reset_Game`.
- Scores saturate at `WINS_TO_MATCH` and never wrap.
- `Reset_n` takes effect at any time, including mid-HOLD: it clears everything asynchronously with no `Reset_Round` pulse. `Reset_Game` does the same synchronously.

## Timing
- Crash sampled at edge N in PLAY:
  - Score and `Round_Over` are updated after edge N.
  - `Round_Over` stays high for exactly `HOLD_CYCLES` cycles.
- Non-final round: `Reset_Round` is high for the single cycle following HOLD, i.e. after edge N+`HOLD_CYCLES`. The game state machine reaches Round_Paused one edge later.
- Final round: `Blue_W`/`Red_W` rise after edge N+`HOLD_CYCLES`. The game state machine consumes the level the next cycle.
- IDLE→PLAY latency: 1 cycle after `Game_State` becomes 2.

## Test plan
- `HOLD_CYCLES`=4, `WINS_TO_MATCH`=3. Sequence: Menu, then Round_Paused, then Round_Started, then `Red_Crash` for 1 cycle.
  - Expect `Blue_Score`=1 and `Round_Over` high for 4 cycles.
  - Expect `Reset_Round` high for exactly 1 cycle, with `Blue_W`=0.
- Three blue round wins in a row: after the third HOLD, `Blue_W`=1 is held and `Red_W`=0. Then `Game_State`=0 → `Blue_W`=0 and both scores are 0 next cycle.
- `Blue_Crash` and `Red_Crash` asserted in the same cycle → `Draw`=1, scores unchanged, `Reset_Round` pulse after 4 cycles.
- `Red_Crash` held high through the whole HOLD → only one increment (`Blue_Score`=1).
- `Reset_n`=0 two cycles into HOLD → all outputs 0 immediately. No `Reset_Round` pulse after release, and state is IDLE.
- `Game_State` held at 2 after the ARM pulse (the game state machine stalls) → no re-entry to PLAY until `Game_State` drops and returns to 2.
